// File: rtl/hazard_ctrl_mc.sv
// Hazard and forwarding controller for the five-stage core: forwarding selects,
// load-use and multi-cycle Execute stalls, branch flushes, saturating perf counters.
module hazard_ctrl_mc #(
  parameter int AW         = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    RA1D,
  input  logic [AW-1:0]    RA2D,
  input  logic             UseRA1D,
  input  logic             UseRA2D,
  input  logic [AW-1:0]    RA1E,
  input  logic [AW-1:0]    RA2E,
  input  logic [AW-1:0]    WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MultiE,
  input  logic             BranchTakenE,
  input  logic [AW-1:0]    WA3M,
  input  logic             RegWriteM,
  input  logic [AW-1:0]    WA3W,
  input  logic             RegWriteW,
  input  logic             ClearCnt,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic {IDLE, BUSY} mulState_t;

  localparam logic [AW-1:0] PC_REG = '1;
  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_LOAD = (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);

  mulState_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic            mulStall;
  logic            ldStall;

  // The PC register is never forwarded; M results take priority over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RA1E == WA3M) && (RA1E != PC_REG))
        ForwardAE = 2'b10;
      else if (RegWriteW && (RA1E == WA3W) && (RA1E != PC_REG))
        ForwardAE = 2'b01;
      if (RegWriteM && (RA2E == WA3M) && (RA2E != PC_REG))
        ForwardBE = 2'b10;
      else if (RegWriteW && (RA2E == WA3W) && (RA2E != PC_REG))
        ForwardBE = 2'b01;
    end
  end

  assign ldStall = MemtoRegE & RegWriteE &
                   ((UseRA1D & (RA1D == WA3E)) | (UseRA2D & (RA2D == WA3E)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mulStall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MultiE && MUL_MULTI && !BranchTakenE) begin
          mulStall = 1'b1;
          state_d  = BUSY;
          cnt_d    = CNT_LOAD;
        end
      end
      BUSY: begin
        // The final BUSY cycle releases the pipe; the op leaves Execute at its edge.
        if (cnt_q != '0) begin
          mulStall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MulBusy = (state_q == BUSY);

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleM = 1'b0;
    if (reset) begin
      FlushD  = 1'b1;
      FlushE  = 1'b1;
      BubbleM = 1'b1;
    end else if (mulStall) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      BubbleM = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ldStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (reset || ClearCnt) begin
      stallCnt_d = '0;
      flushCnt_d = '0;
    end else begin
      if (StallD && (stallCnt_q != '1))
        stallCnt_d = stallCnt_q + 1'b1;
      if (FlushE && (flushCnt_q != '1))
        flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    stallCnt_q <= stallCnt_d;
    flushCnt_q <= flushCnt_d;
  end

  assign StallCnt = stallCnt_q;
  assign FlushCnt = flushCnt_q;

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard and forwarding controller for the five-stage pipelined core. It generates forwarding selects, stall and flush controls for the pipeline registers between Fetch, Decode, Execute, Memory and Writeback. It adds three things the current fixed-width hazard logic does not have:
- a configurable register-address width;
- a multi-cycle Execute state machine for long/multiply operations that holds Execute and injects bubbles into Memory;
- saturating stall and flush performance counters.

## Interface
Parameters:
- AW, 4: register address width; register 2^AW-1 is the PC and is never forwarded.
- MUL_CYCLES, 3: Execute occupancy of a multi-cycle op; legal range 1 to 16.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high.
- RA1D, RA2D  in  AW each  Decode source addresses.
- UseRA1D, UseRA2D  in  1 each  high when the Decode source is actually read.
- RA1E, RA2E  in  AW each  Execute source addresses.
- WA3E  in  AW  Execute destination.
- RegWriteE, MemtoRegE, MultiE, BranchTakenE  in  1 each  Execute controls.
- WA3M  in  AW  Memory destination.
- RegWriteM  in  1  Memory write enable.
- WA3W  in  AW  Writeback destination.
- RegWriteW  in  1  Writeback write enable.
- ClearCnt  in  1  synchronous clear of both counters.
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM.
- StallF, StallD, StallE  out  1 each  high means hold the corresponding register.
- FlushD, FlushE  out  1 each  high means clear the corresponding register on the next edge.
- BubbleM  out  1  clear the Execute-to-Memory register.
- MulBusy  out  1  multi-cycle state machine is in BUSY.
- StallCnt, FlushCnt  out  CNT_W each  performance counters.

## Operation
Forwarding (combinational):
- ForwardAE = 10 when RegWriteM, RA1E==WA3M and RA1E != 2^AW-1.
- Otherwise ForwardAE = 01 under the same test against W (RegWriteW, RA1E==WA3W).
- Otherwise ForwardAE = 00.
- ForwardBE uses the same rules with RA2E. M always has priority over W.

Load-use hazard:
- LdStall = MemtoRegE & RegWriteE & ((UseRA1D & RA1D==WA3E) | (UseRA2D & RA2D==WA3E)).

Multi-cycle state machine, with states IDLE and BUSY and a down-counter cnt:
- IDLE with MultiE=1, MUL_CYCLES>1 and no BranchTakenE: MulStall=1; next state BUSY, cnt loads MUL_CYCLES-2.
- BUSY with cnt!=0: MulStall=1; cnt decrements.
- BUSY with cnt==0: MulStall=0; next state IDLE. The op leaves Execute at this edge.
- MUL_CYCLES=1: the machine never leaves IDLE.
- The multi-cycle unit latches its operands in the op's first Execute cycle; forwarding selects during later BUSY cycles are don't-care for it.

Output priority, highest first:
1. reset: StallF/D/E=0, FlushD=FlushE=1, BubbleM=1, Forward*=00.
2. MulStall: StallF=StallD=StallE=1, BubbleM=1, FlushD=FlushE=0. LdStall and BranchTakenE are ignored in these cycles.
3. BranchTakenE: FlushD=FlushE=1, no stalls. A simultaneous LdStall is discarded, because the D instruction is squashed.
4. LdStall: StallF=StallD=1, FlushE=1, StallE=0.
5. Otherwise: all stall and flush outputs 0, BubbleM=0.

Counters:
- StallCnt increments on every cycle with StallD=1.
- FlushCnt increments on every cycle with FlushE=1 outside reset.
- Both saturate at all-ones and are zeroed by reset or ClearCnt.
- ClearCnt has priority over increment.

## Timing
- All control outputs are combinational from the inputs and registered state, valid in the same cycle.
- State, cnt and counters change only on the rising edge.
- A multi-cycle op occupies Execute for exactly MUL_CYCLES cycles and produces exactly MUL_CYCLES-1 stall cycles and MUL_CYCLES-1 M bubbles.
- Back-to-back multi-cycle ops: the second op starts in IDLE on the cycle after the first leaves, with no gap cycle.
- Reset while BUSY: the state returns to IDLE with cnt=0 on that edge; MulBusy=0 from the next cycle.
- Reset values: state IDLE, cnt 0, MulBusy 0, StallCnt 0, FlushCnt 0.

## Test plan
- Forward priority: RegWriteM=RegWriteW=1, WA3M=WA3W=RA1E=3 -> ForwardAE=10. With RegWriteM=0 -> 01. With RA1E=15 -> 00.
- Load-use: MemtoRegE=RegWriteE=1, WA3E=5, RA2D=5, UseRA2D=1 -> StallF=StallD=FlushE=1 for one cycle. With UseRA2D=0 -> no stall.
- Multi-cycle, MUL_CYCLES=3: MultiE held until the op leaves -> StallE high for 2 cycles, BubbleM high for 2 cycles, MulBusy high for 2 cycles, then IDLE. Rerun with MUL_CYCLES=1 -> no stall.
- Simultaneous events: BranchTakenE and LdStall together -> FlushD=FlushE=1, StallD=0. MultiE and BranchTakenE together in IDLE -> no BUSY entry.
- Reset mid-BUSY: assert reset in the first BUSY cycle -> next cycle MulBusy=0, cnt=0; flushes are high while reset is high.
- Counters with CNT_W=2: 5 load-use cycles -> StallCnt=3 (saturated). ClearCnt pulse -> StallCnt=0 and FlushCnt=0 on the next edge.
